// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32
// Brief    : Byte-serial IEEE 802.3 CRC-32 engine for the MAC receive path.
//            Folds one byte per valid clock into a reflected CRC-32 state,
//            presents the complemented running value as the FCS, and pulses
//            ok when the state reaches the 802.3 residue.
// Revision : 1.0 - initial release
// ============================================================================
module eth_crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dat,
  input  logic        val,
  output logic        ok,
  output logic [31:0] crc
);

  // Reflected form of 0x04C11DB7; the shift register moves toward bit 0.
  localparam logic [31:0] C_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] C_INIT      = 32'hFFFFFFFF;
  // Uncomplemented state left behind once a frame and its own FCS are folded.
  localparam logic [31:0] C_RESIDUE   = 32'hDEBB20E3;

  logic [31:0]       r_state;
  logic [31:0]       r_fcs;
  logic              r_ok;

  // w_stage[k] is the state after k bits of the current byte; w_stage[8]
  // is the fully folded next state.
  logic [8:0][31:0]  w_stage;
  logic [31:0]       w_next;
  logic              w_hit;

  assign w_stage[0] = r_state;

  // One unrolled LSB-first shift/XOR stage per data bit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic w_fb;
      assign w_fb           = w_stage[gi][0] ^ dat[gi];
      assign w_stage[gi+1]  = (w_stage[gi] >> 1) ^ (w_fb ? C_POLY_REFL : 32'h0000_0000);
    end
  endgenerate

  assign w_next = w_stage[8];
  assign w_hit  = (w_next == C_RESIDUE);

  // State, FCS and check pulse; reset wins over a valid byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_INIT;
      r_fcs   <= 32'h0000_0000;
      r_ok    <= 1'b0;
    end else if (val) begin
      r_state <= w_next;
      r_fcs   <= ~w_next;
      r_ok    <= w_hit;
    end else begin
      r_ok    <= 1'b0;
    end
  end

  assign ok  = r_ok;
  assign crc = r_fcs;

endmodule
`default_nettype wire

// File: tb/tb_eth_crc32.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_crc32
// Brief    : Scoreboard bench for eth_crc32. The driver pushes the expected
//            (crc, ok) pair for every cycle it drives; a monitor pops and
//            compares after each rising edge. The reference model computes
//            the CRC from scratch over the whole accepted byte list using the
//            non-reflected MSB-first polynomial division and a bit reversal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_crc32;

  logic        clk;
  logic        rst;
  logic [7:0]  dat;
  logic        val;
  logic        ok;
  logic [31:0] crc;

  int n_checks = 0;
  int n_fail   = 0;
  int ok_seen  = 0;

  logic [7:0]  frame [$];
  logic [32:0] exp_q [$];
  logic [31:0] m_crc = 32'h0;
  logic        m_ok  = 1'b0;

  eth_crc32 u_dut (
    .clk (clk),
    .rst (rst),
    .dat (dat),
    .val (val),
    .ok  (ok),
    .crc (crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reflected CRC state of every byte accepted since reset, via plain
  // MSB-first long division over the LSB-first wire bit order.
  function automatic logic [31:0] ref_state();
    logic [31:0] r;
    logic [31:0] rev;
    logic        top;
    r = 32'hFFFFFFFF;
    foreach (frame[k]) begin
      for (int i = 0; i < 8; i++) begin
        top = r[31] ^ frame[k][i];
        r   = {r[30:0], 1'b0} ^ (top ? 32'h04C11DB7 : 32'h0);
      end
    end
    for (int i = 0; i < 32; i++) rev[i] = r[31-i];
    return rev;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Drive one cycle and record what the DUT must show after the next edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic [31:0] c;
    @(negedge clk);
    rst = r;
    val = v;
    dat = d;
    if (r) begin
      frame.delete();
      m_crc = 32'h0;
      m_ok  = 1'b0;
    end else if (v) begin
      frame.push_back(d);
      c     = ref_state();
      m_crc = ~c;
      m_ok  = (c == 32'hDEBB20E3);
    end else begin
      m_ok  = 1'b0;
    end
    exp_q.push_back({m_ok, m_crc});
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered output against the scoreboard.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (ok === 1'b1) ok_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (crc !== e[31:0] || ok !== e[32]) begin
        n_fail++;
        $display("FAIL scoreboard: got crc=%08h ok=%b expected crc=%08h ok=%b",
                 crc, ok, e[31:0], e[32]);
      end
    end
  end

  logic [7:0] msg [13];
  logic [7:0] b;
  logic [31:0] c_fcs;
  int          bitpos;
  int          len;

  initial begin
    rst = 1'b1;
    val = 1'b0;
    dat = 8'h00;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset then idle.
    cycle(1'b1, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'hA5);
    sample();
    check32("reset_crc", crc, 32'h0);
    check32("reset_ok", {31'h0, ok}, 32'h0);

    // Check string.
    ok_seen = 0;
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, msg[i]);
    sample();
    check32("check_string_crc", crc, 32'hCBF43926);
    cycle(1'b0, 1'b0, 8'h00);
    sample();
    check32("check_string_no_ok", ok_seen, 0);

    // Check string plus its FCS gives a one-cycle ok.
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, msg[i]);
    sample();
    check32("fcs_ok_pulse", {31'h0, ok}, 32'h1);
    cycle(1'b0, 1'b0, 8'h00);
    sample();
    check32("fcs_ok_drop", {31'h0, ok}, 32'h0);

    // Single-bit corruptions never produce ok.
    for (int t = 0; t < 8; t++) begin
      bitpos = $urandom_range(0, 103);
      cycle(1'b1, 1'b0, 8'h00);
      ok_seen = 0;
      for (int i = 0; i < 13; i++) begin
        b = msg[i];
        if (i == bitpos / 8) b[bitpos % 8] = ~b[bitpos % 8];
        cycle(1'b0, 1'b1, b);
      end
      cycle(1'b0, 1'b0, 8'h00);
      sample();
      check32("corrupt_no_ok", ok_seen, 0);
    end

    // Single zero byte.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    sample();
    check32("zero_byte_crc", crc, 32'hD202EF8D);

    // Check string with random gaps.
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, msg[i]);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, $urandom_range(0, 255));
    end
    sample();
    check32("gapped_crc", crc, 32'hCBF43926);

    // Reset mid-frame, then check string.
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, $urandom_range(0, 255));
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, msg[i]);
    sample();
    check32("midframe_reset_crc", crc, 32'hCBF43926);

    // Reset together with val discards the byte.
    cycle(1'b1, 1'b1, 8'h5A);
    sample();
    check32("rst_with_val_crc", crc, 32'h0);
    cycle(1'b0, 1'b1, 8'h00);
    sample();
    check32("rst_with_val_discard", crc, 32'hD202EF8D);

    // Random frames with random gaps, closed by their own FCS.
    for (int f = 0; f < 12; f++) begin
      cycle(1'b1, 1'b0, 8'h00);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 255));
      end
      c_fcs = m_crc;
      if (frame.size() == 0) c_fcs = 32'h0;
      if (frame.size() > 0) begin
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, c_fcs[8*k +: 8]);
        sample();
        check32("random_fcs_ok", {31'h0, ok}, 32'h1);
      end
      cycle(1'b0, 1'b0, 8'h00);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check32("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
